zdelta_plane_streamer: RTL and testbench

Plane-to-stream reader for the Z-delta correction path. Captures a complete corrected plane of `N_WORDS` samples from `zdelta_core`'s output, double-buffers it, and emits it word by word over a valid/ready stream toward the DAC/CRT drive side. Frames carry first/last markers and a closing 16-bit checksum. A plane offered while one is still pending is counted as an overrun.

---
 rtl/zdelta_plane_streamer.sv | 156 +++++++++++++++
 tb/tb_zdelta_plane_streamer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zdelta_plane_streamer.sv
// Double-buffered plane-to-stream reader for the Z-delta correction path.
// A captured plane is sent word by word over valid/ready, then a 16-bit checksum is published.
//
// state  | meaning
// S_IDLE | no frame in flight; waits for a pending plane in shadow
// S_SEND | streaming active[idx]; a pending shadow is chained on the last beat
module zdelta_plane_streamer #(
  parameter int N_WORDS = 20,
  parameter int W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_WORDS*W-1:0] plane_in,
  input  logic                 plane_load,
  output logic [W-1:0]         tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 tx_first,
  output logic                 tx_last,
  output logic [W-1:0]         frame_sum,
  output logic                 sum_valid,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 ovr_clr
);

  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t               r_state;
  logic [N_WORDS*W-1:0] r_shadow;
  logic [N_WORDS*W-1:0] r_active;
  logic                 r_shadow_full;
  logic [IW-1:0]        r_idx;
  logic [W-1:0]         r_sum_acc;
  logic [W-1:0]         r_frame_sum;
  logic                 r_sum_valid;
  logic                 r_overrun;
  logic [W-1:0]         r_tx_data;
  logic                 r_tx_first;
  logic                 r_tx_last;

  state_t               w_state_nxt;
  logic [IW-1:0]        w_idx_nxt;
  logic [N_WORDS*W-1:0] w_active_nxt;
  logic [W-1:0]         w_word;
  logic [W-1:0]         w_data_nxt;
  logic                 w_first_nxt;
  logic                 w_last_nxt;
  logic                 w_hs;
  logic                 w_last_hs;
  logic                 w_xfer;

  assign w_hs      = (r_state == S_SEND) & tx_ready;
  assign w_last_hs = w_hs & (r_idx == LAST_IDX);
  // The shadow moves to active either from idle or on the closing beat of a frame.
  assign w_xfer    = r_shadow_full & ((r_state == S_IDLE) | w_last_hs);
  assign w_word    = r_active[int'(r_idx)*W +: W];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = '0;
        end
      end
      S_SEND: begin
        if (w_last_hs) begin
          w_state_nxt = w_xfer ? S_SEND : S_IDLE;
          w_idx_nxt   = '0;
        end else if (w_hs) begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase

    // Output registers are loaded with what the next cycle presents, so a stall holds them.
    w_active_nxt = w_xfer ? r_shadow : r_active;
    w_data_nxt   = '0;
    w_first_nxt  = 1'b0;
    w_last_nxt   = 1'b0;
    if (w_state_nxt == S_SEND) begin
      w_data_nxt  = w_active_nxt[int'(w_idx_nxt)*W +: W];
      w_first_nxt = (w_idx_nxt == '0);
      w_last_nxt  = (w_idx_nxt == LAST_IDX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_shadow      <= '0;
      r_active      <= '0;
      r_shadow_full <= 1'b0;
      r_idx         <= '0;
      r_sum_acc     <= '0;
      r_frame_sum   <= '0;
      r_sum_valid   <= 1'b0;
      r_overrun     <= 1'b0;
      r_tx_data     <= '0;
      r_tx_first    <= 1'b0;
      r_tx_last     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_active   <= w_active_nxt;
      r_tx_data  <= w_data_nxt;
      r_tx_first <= w_first_nxt;
      r_tx_last  <= w_last_nxt;

      if (plane_load) begin
        r_shadow      <= plane_in;
        r_shadow_full <= 1'b1;
      end else if (w_xfer) begin
        r_shadow_full <= 1'b0;
      end

      // Newest plane wins; a clear in the same cycle as a fresh overrun loses.
      if (plane_load & r_shadow_full & ~w_xfer) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end

      if (w_xfer) begin
        r_sum_acc <= '0;
      end else if (w_hs) begin
        r_sum_acc <= r_sum_acc + w_word;
      end

      r_sum_valid <= w_last_hs;
      if (w_last_hs) begin
        r_frame_sum <= r_sum_acc + w_word;
      end
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = (r_state == S_SEND);
  assign tx_first  = r_tx_first;
  assign tx_last   = r_tx_last;
  assign frame_sum = r_frame_sum;
  assign sum_valid = r_sum_valid;
  assign overrun   = r_overrun;
  assign busy      = (r_state == S_SEND) | r_shadow_full;

endmodule

// File: tb/tb_zdelta_plane_streamer.sv
// Self-checking bench for zdelta_plane_streamer: frame-level reference model plus directed scenarios.
module tb_zdelta_plane_streamer;
  localparam int N = 20;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] plane_in;
  logic           plane_load;
  logic [W-1:0]   tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           tx_first;
  logic           tx_last;
  logic [W-1:0]   frame_sum;
  logic           sum_valid;
  logic           busy;
  logic           overrun;
  logic           ovr_clr;

  zdelta_plane_streamer #(.N_WORDS(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .plane_in(plane_in), .plane_load(plane_load),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_first(tx_first), .tx_last(tx_last), .frame_sum(frame_sum),
    .sum_valid(sum_valid), .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [N*W-1:0] mk(input logic [W-1:0] base, input logic [W-1:0] inc);
    logic [N*W-1:0] p;
    for (int i = 0; i < N; i++) p[i*W +: W] = base + W'(i) * inc;
    return p;
  endfunction

  function automatic logic [W-1:0] wd(input logic [N*W-1:0] p, input int i);
    return p[i*W +: W];
  endfunction

  function automatic logic [W-1:0] plane_sum(input logic [N*W-1:0] p);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + p[i*W +: W];
    return s;
  endfunction

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Reference model: the frame being sent, its beat number, and at most one pending plane.
  bit             m_stream = 0;
  int             m_beat = 0;
  logic [N*W-1:0] m_cur = '0;
  logic [N*W-1:0] m_pend = '0;
  bit             m_pend_v = 0;
  bit             m_ovr = 0;
  bit             m_sv = 0;
  logic [W-1:0]   m_sum = '0;

  task automatic model_step();
    bit hs, fin, start;
    if (!rst_n) begin
      m_stream = 0; m_beat = 0; m_cur = '0; m_pend = '0;
      m_pend_v = 0; m_ovr = 0; m_sv = 0; m_sum = '0;
    end else begin
      hs    = m_stream && tx_ready;
      fin   = hs && (m_beat == N - 1);
      start = m_pend_v && (!m_stream || fin);
      m_sv  = fin;
      if (fin) m_sum = plane_sum(m_cur);
      if (plane_load && m_pend_v && !start) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
      if (start) begin
        m_cur = m_pend; m_beat = 0; m_stream = 1;
      end else if (fin) begin
        m_stream = 0; m_beat = 0;
      end else if (hs) begin
        m_beat++;
      end
      if (plane_load) begin
        m_pend = plane_in; m_pend_v = 1;
      end else if (start) begin
        m_pend_v = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("tx_valid", 32'(tx_valid), 32'(m_stream));
    if (m_stream) begin
      chk("tx_data", 32'(tx_data), 32'(wd(m_cur, m_beat)));
      chk("tx_first", 32'(tx_first), 32'(m_beat == 0));
      chk("tx_last", 32'(tx_last), 32'(m_beat == N - 1));
    end
    chk("sum_valid", 32'(sum_valid), 32'(m_sv));
    chk("frame_sum", 32'(frame_sum), 32'(m_sum));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("busy", 32'(busy), 32'(m_stream || m_pend_v));
  end

  // Beat monitor: accepted words, frame boundaries, checksum pulses, stall stability.
  int acc_q[$];
  int first_q[$];
  int last_edge_q[$];
  int sv_q[$];
  bit p_stall = 0;
  logic [W-1:0] p_data;
  logic p_first, p_last;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (p_stall) begin
        chk("stall_data", 32'(tx_data), 32'(p_data));
        chk("stall_first", 32'(tx_first), 32'(p_first));
        chk("stall_last", 32'(tx_last), 32'(p_last));
      end
      if (tx_valid && tx_first && !p_stall) first_q.push_back(cyc);
      if (tx_valid && tx_ready) begin
        acc_q.push_back(int'(tx_data));
        if (tx_last) last_edge_q.push_back(cyc + 1);
      end
      if (sum_valid) sv_q.push_back(cyc);
      p_stall = tx_valid && !tx_ready;
      p_data  = tx_data;
      p_first = tx_first;
      p_last  = tx_last;
    end else begin
      p_stall = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    acc_q.delete(); first_q.delete(); last_edge_q.delete(); sv_q.delete();
  endtask

  task automatic load(input logic [N*W-1:0] p);
    plane_in   = p;
    plane_load = 1'b1;
    step();
    plane_load = 1'b0;
  endtask

  task automatic wait_sums(input int k, input int budget);
    int t;
    t = 0;
    while (sv_q.size() < k && t < budget) begin
      step();
      t++;
    end
    chk("wait_sum_timeout", 32'(sv_q.size() >= k), 32'd1);
  endtask

  logic [N*W-1:0] pa, pb, pc, pd, pe, pf, pg;
  int lc;

  initial begin
    pa = mk(16'h0000, 16'h0101);
    pb = mk(16'hB000, 16'h0001);
    pc = mk(16'hC000, 16'h0001);
    pd = mk(16'hD000, 16'h0001);
    pe = mk(16'hE000, 16'h0001);
    pf = mk(16'hF000, 16'h0001);
    pg = mk(16'h9000, 16'h0001);
    rst_n = 1'b0; plane_load = 1'b0; plane_in = '0; tx_ready = 1'b1; ovr_clr = 1'b0;
    repeat (3) step();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_frame_sum", 32'(frame_sum), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    step();

    // Single frame; sum of 0..19 is 190 = 0xBE, times 0x0101.
    clear_q();
    load(pa);
    lc = cyc;
    wait_sums(1, 100);
    chk("t1_count", 32'(acc_q.size()), 32'd20);
    chk("t1_word0", 32'(qi(acc_q, 0)), 32'h0000);
    chk("t1_word19", 32'(qi(acc_q, 19)), 32'h1313);
    chk("t1_sum", 32'(frame_sum), 32'hBEBE);
    chk("t1_latency", 32'(qi(first_q, 0)), 32'(lc + 1));
    chk("t1_throughput", 32'(qi(last_edge_q, 0)), 32'(qi(first_q, 0) + N));
    chk("t1_sum_timing", 32'(qi(sv_q, 0)), 32'(qi(last_edge_q, 0)));
    step();

    // Backpressure: ready 1,0,0 repeating, with a 5-cycle hold at beat 10.
    clear_q();
    tx_ready = 1'b1;
    load(pa);
    begin
      int c, hold;
      bit held;
      c = 0; hold = 0; held = 0;
      while (sv_q.size() < 1 && c < 300) begin
        if (hold > 0) begin
          tx_ready = 1'b0; hold--;
        end else if (!held && acc_q.size() == 10) begin
          held = 1; hold = 4; tx_ready = 1'b0;
        end else begin
          tx_ready = (c % 3 == 0);
        end
        step();
        c++;
      end
    end
    tx_ready = 1'b1;
    chk("t2_count", 32'(acc_q.size()), 32'd20);
    for (int i = 0; i < N; i++) chk("t2_order", 32'(qi(acc_q, i)), 32'(i * 16'h0101));
    chk("t2_sum", 32'(frame_sum), 32'hBEBE);
    step();

    // Back-to-back: B loaded 3 cycles into A's stream.
    clear_q();
    load(pa);
    repeat (3) step();
    load(pb);
    wait_sums(2, 150);
    chk("t3_no_gap", 32'(qi(first_q, 1)), 32'(qi(last_edge_q, 0)));
    chk("t3_b_first", 32'(qi(acc_q, 20)), 32'hB000);
    chk("t3_b_last", 32'(qi(acc_q, 39)), 32'hB013);
    chk("t3_overrun", 32'(overrun), 32'd0);
    step();

    // Overrun: B then C while A streams; C wins.
    clear_q();
    load(pa);
    repeat (2) step();
    load(pb);
    step();
    load(pc);
    wait_sums(2, 150);
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_count", 32'(acc_q.size()), 32'd40);
    chk("t4_c_first", 32'(qi(acc_q, 20)), 32'hC000);
    chk("t4_c_last", 32'(qi(acc_q, 39)), 32'hC013);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("t4_clr", 32'(overrun), 32'd0);
    plane_in = pe; plane_load = 1'b1;
    step();
    plane_in = pf;
    step();
    chk("t4_load_on_xfer", 32'(overrun), 32'd0);
    plane_in = pg; ovr_clr = 1'b1;
    step();
    plane_load = 1'b0; ovr_clr = 1'b0;
    chk("t4_set_wins", 32'(overrun), 32'd1);
    wait_sums(4, 150);
    chk("t4_e_first", 32'(qi(acc_q, 40)), 32'hE000);
    chk("t4_g_first", 32'(qi(acc_q, 60)), 32'h9000);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    step();

    // Load racing the transfer at A's last handshake while B is pending.
    clear_q();
    load(pa);
    repeat (3) step();
    load(pb);
    begin
      int t;
      t = 0;
      while (!(tx_valid && tx_last) && t < 100) begin
        step();
        t++;
      end
      chk("t5_find_last", 32'(tx_valid && tx_last), 32'd1);
    end
    load(pd);
    wait_sums(3, 150);
    chk("t5_count", 32'(acc_q.size()), 32'd60);
    chk("t5_b_next", 32'(qi(acc_q, 20)), 32'hB000);
    chk("t5_d_next", 32'(qi(acc_q, 40)), 32'hD000);
    chk("t5_overrun", 32'(overrun), 32'd0);
    chk("t5_gap_ab", 32'(qi(first_q, 1)), 32'(qi(last_edge_q, 0)));
    chk("t5_gap_bd", 32'(qi(first_q, 2)), 32'(qi(last_edge_q, 1)));
    step();

    // Reset at beat 7 with B pending.
    clear_q();
    load(pa);
    repeat (2) step();
    load(pb);
    begin
      int t;
      t = 0;
      while (acc_q.size() < 7 && t < 100) begin
        step();
        t++;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(tx_valid), 32'd0);
    chk("t6_data", 32'(tx_data), 32'd0);
    chk("t6_first", 32'(tx_first), 32'd0);
    chk("t6_last", 32'(tx_last), 32'd0);
    chk("t6_sum_valid", 32'(sum_valid), 32'd0);
    chk("t6_frame_sum", 32'(frame_sum), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_overrun", 32'(overrun), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("t6_no_sum", 32'(sv_q.size()), 32'd0);
    chk("t6_no_last", 32'(last_edge_q.size()), 32'd0);
    chk("t6_pending_dropped", 32'(tx_valid | busy), 32'd0);
    clear_q();
    load(pd);
    wait_sums(1, 100);
    chk("t6_count", 32'(acc_q.size()), 32'd20);
    chk("t6_word0", 32'(qi(acc_q, 0)), 32'hD000);
    chk("t6_word19", 32'(qi(acc_q, 19)), 32'hD013);
    chk("t6_sum", 32'(frame_sum), 32'h40BE);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
